// File: rtl/sirv_debug_ram_arb.sv
// Two-port (debug module / core) arbiter in front of an 8-word RAM, one transaction in flight.
// Define SIRV_DEBUG_RAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sirv_debug_ram_arb (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        dmi_cmd_valid,
  output logic        dmi_cmd_ready,
  input  logic        dmi_cmd_read,
  input  logic [2:0]  dmi_cmd_addr,
  input  logic [31:0] dmi_cmd_wdata,
  output logic        dmi_rsp_valid,
  input  logic        dmi_rsp_ready,
  output logic [31:0] dmi_rsp_rdata,
  output logic        dmi_rsp_err,

  input  logic        core_cmd_valid,
  output logic        core_cmd_ready,
  input  logic        core_cmd_read,
  input  logic [2:0]  core_cmd_addr,
  input  logic [31:0] core_cmd_wdata,
  output logic        core_rsp_valid,
  input  logic        core_rsp_ready,
  output logic [31:0] core_rsp_rdata,
  output logic        core_rsp_err,

  output logic        ram_cs,
  output logic        ram_rd,
  output logic [2:0]  ram_addr,
  output logic [31:0] ram_wdat,
  input  logic [31:0] ram_dout
);

  typedef enum logic {StIdle, StRsp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        win;
  logic        grant;
  logic        sel_read;
  logic [2:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_ok;
  logic        rsp_valid;
  logic        rsp_ready;

  assign grant = (state_q == StIdle) && (dmi_cmd_valid || core_cmd_valid);

`ifdef SIRV_DEBUG_RAM_ARB_RR_EN
  // prefer_q names the port that wins the next contention (1 = core).
  logic prefer_q, prefer_d;

  always_comb begin
    win      = core_cmd_valid;
    prefer_d = prefer_q;
    if (dmi_cmd_valid && core_cmd_valid) begin
      win = prefer_q;
    end
    if (grant) begin
      prefer_d = ~win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prefer_q <= 1'b0;
    end else begin
      prefer_q <= prefer_d;
    end
  end
`else
  assign win = core_cmd_valid && !dmi_cmd_valid;
`endif

  assign sel_read  = win ? core_cmd_read  : dmi_cmd_read;
  assign sel_addr  = win ? core_cmd_addr  : dmi_cmd_addr;
  assign sel_wdata = win ? core_cmd_wdata : dmi_cmd_wdata;
  assign addr_ok   = (sel_addr != 3'd7);

  assign dmi_cmd_ready  = grant && !win;
  assign core_cmd_ready = grant && win;

  // Reset gates the RAM select and responses so nothing leaks out during reset.
  assign ram_cs   = grant && addr_ok && rst_n;
  assign ram_rd   = sel_read;
  assign ram_addr = sel_addr;
  assign ram_wdat = sel_wdata;

  assign rsp_valid      = (state_q == StRsp) && rst_n;
  assign dmi_rsp_valid  = rsp_valid && !owner_q;
  assign core_rsp_valid = rsp_valid && owner_q;
  assign dmi_rsp_rdata  = rdata_q;
  assign core_rsp_rdata = rdata_q;
  assign dmi_rsp_err    = err_q;
  assign core_rsp_err   = err_q;
  assign rsp_ready      = owner_q ? core_rsp_ready : dmi_rsp_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StRsp;
          owner_d = win;
          rdata_d = (sel_read && addr_ok) ? ram_dout : 32'd0;
          err_d   = !addr_ok;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/sirv_debug_ram_arb.md
SIRV_DEBUG_RAM_ARB -- requirements
Module: sirv_debug_ram_arb

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 dmi_cmd_valid / dmi_cmd_ready  input / output  1 / 1  port 0 (debug module) command handshake.
REQ-005 dmi_cmd_read  input  1  1 = read, 0 = write.
REQ-006 dmi_cmd_addr  input  3  RAM word index.
REQ-007 dmi_cmd_wdata  input  32  write data.
REQ-008 dmi_rsp_valid / dmi_rsp_ready  output / input  1 / 1  port 0 response handshake.
REQ-009 dmi_rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-010 dmi_rsp_err  output  1  response error flag.
REQ-011 core_cmd_* and core_rsp_*  same directions and widths as REQ-004..REQ-010  port 1 (core fetch/load-store).
REQ-012 ram_cs, ram_rd  output  1  RAM select and read (ram_rd=0 with ram_cs=1 is a write).
REQ-013 ram_addr  output  3  RAM index.
REQ-014 ram_wdat  output  32  RAM write data.
REQ-015 ram_dout  input  32  combinational RAM read data for the current ram_addr.

Function
REQ-016 FSM states SHALL be IDLE and RSP, with at most one transaction outstanding.
REQ-017 In IDLE with at least one cmd_valid, the arbiter SHALL pick one winner and assert that port's cmd_ready combinationally in the same cycle; the loser's cmd_ready SHALL be 0.
REQ-018 In RSP, cmd_ready SHALL be 0 on both ports.
REQ-019 In the grant cycle, for a legal address (0..6), the block SHALL drive ram_cs=1, ram_rd=cmd_read, ram_addr=cmd_addr and ram_wdat=cmd_wdata; in all other cycles ram_cs SHALL be 0.
REQ-020 On grant, the block SHALL register: rdata = ram_dout (read) or 0 (write), err = 0, and the owner port; FSM then goes to RSP.
REQ-021 For address 7, the block SHALL grant the command, keep ram_cs=0, and register rdata=0 and err=1.
REQ-022 In RSP, only the owner's rsp_valid SHALL be 1, carrying the registered rdata and err; the other port's rsp_valid SHALL be 0.
REQ-023 The FSM SHALL stay in RSP while rsp_ready=0, holding rdata and err stable, and SHALL return to IDLE on the cycle after rsp_valid&rsp_ready.
REQ-024 A new grant SHALL NOT occur in the cycle of the response handshake, so back-to-back throughput is at most one transaction per 2 cycles and command-to-rsp_valid latency is 1 cycle.
REQ-025 cmd_ready SHALL NOT depend on rsp_ready.
REQ-026 If a port deasserts cmd_valid before it is granted, no RAM access SHALL occur for that port.

Reset
REQ-027 With rst_n=0 at a rising edge: FSM = IDLE, owner = port 0, rdata = 0, err = 0, round-robin pointer = port 0 preferred.
REQ-028 During and after reset: all rsp_valid = 0, ram_cs = 0, and cmd_ready follows REQ-017 from IDLE.
REQ-029 Reset asserted in RSP SHALL drop the pending response without any RAM access.

Configuration
REQ-030 With SIRV_DEBUG_RAM_ARB_RR_EN defined: round-robin arbitration.
  - On contention, the port not granted last wins.
  - The pointer updates only on a grant.
REQ-031 Without SIRV_DEBUG_RAM_ARB_RR_EN: fixed priority, port 0 (dmi) always wins on contention, and no pointer state exists.

Verification
REQ-032 After reset, dmi write addr 3 data 0xDEADBEEF, then core read addr 3: RAM write seen in grant cycle; core_rsp_rdata=0xDEADBEEF, err=0, one cycle after grant.
REQ-033 Both ports request every cycle, rsp_ready=1:
  - With RR_EN: grants alternate dmi, core, dmi, core, ..., one grant per 2 cycles.
  - Without RR_EN: dmi is granted every time.
REQ-034 core read addr 7: ram_cs stays 0; core_rsp_err=1, rdata=0.
REQ-035 dmi read addr 0, dmi_rsp_ready held 0 for 5 cycles while core_cmd_valid=1: core_cmd_ready=0 throughout; rdata stable; core granted the cycle after the dmi response handshake.
REQ-036 rst_n pulled low while in RSP: next cycle rsp_valid=0, state IDLE, no RAM write.
